// File: rtl/timer_seq_pkg.sv
`default_nettype none
// ============================================================================
// timer_seq_pkg : shared state encoding and packet layout for the timer
//                 configuration sequencer.
// Revision      : 1.0
// ============================================================================
package timer_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_W_STOP = 4'd1,
    ST_W_MIN  = 4'd2,
    ST_W_MAX  = 4'd3,
    ST_W_M0   = 4'd4,
    ST_W_M1   = 4'd5,
    ST_W_INIT = 4'd6,
    ST_W_CTRL = 4'd7,
    ST_DONE   = 4'd8
  } seq_state_t;

  localparam int PKT_W    = 48;
  localparam int MIN_LSB  = 0;
  localparam int MAX_LSB  = 8;
  localparam int M0_LSB   = 16;
  localparam int M1_LSB   = 24;
  localparam int INIT_LSB = 32;
  localparam int CTRL_LSB = 40;

  function automatic logic [7:0] pkt_field(input logic [PKT_W-1:0] pkt, input int lsb);
    return pkt[lsb +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_rr_arb.sv
`default_nettype none
// ============================================================================
// timer_rr_arb : combinational round-robin arbiter; search starts at ptr.
// Revision     : 1.0
// ============================================================================
module timer_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PTR_W-1:0]   owner
);

  localparam int c_sum_w = PTR_W + 1;

  logic               w_found;
  logic [c_sum_w-1:0] w_sum;
  logic [PTR_W-1:0]   w_idx;

  always_comb begin
    winner  = '0;
    owner   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Wrap the candidate index without a divider.
      w_sum = {1'b0, ptr} + c_sum_w'(i);
      if (w_sum >= c_sum_w'(NUM_REQ)) w_sum = w_sum - c_sum_w'(NUM_REQ);
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && req[w_idx]) begin
        w_found       = 1'b1;
        winner[w_idx] = 1'b1;
        owner         = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// timer_cfg_sequencer : arbitrates requesters and replays the winner's packet
//                       as a fixed series of timer register writes.
// Revision            : 1.0
// ============================================================================
module timer_cfg_sequencer
  import timer_seq_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter int         START_BIT = 0,
  parameter logic [5:0] ADDR_CTRL = 6'h00,
  parameter logic [5:0] ADDR_INIT = 6'h04,
  parameter logic [5:0] ADDR_MIN  = 6'h05,
  parameter logic [5:0] ADDR_MAX  = 6'h06,
  parameter logic [5:0] ADDR_M0   = 6'h07,
  parameter logic [5:0] ADDR_M1   = 6'h08
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*PKT_W-1:0] cfg,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [5:0]               addr,
  output logic                     wr_en,
  output logic                     mod_en,
  output logic [7:0]               wdata
);

  localparam int         c_ptr_w      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] c_start_mask = 8'(1) << START_BIT;

  seq_state_t         r_state;
  logic [c_ptr_w-1:0] r_ptr;
  logic [c_ptr_w-1:0] r_owner;
  logic [PKT_W-1:0]   r_hold;

  logic [NUM_REQ-1:0] w_winner;
  logic [c_ptr_w-1:0] w_owner;
  logic [c_ptr_w-1:0] w_next_ptr;
  logic [PKT_W-1:0]   w_sel_cfg;
  logic [NUM_REQ-1:0] w_owner_oh;

  timer_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (c_ptr_w)
  ) u_arb (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .owner  (w_owner)
  );

  always_comb begin
    w_sel_cfg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) w_sel_cfg = cfg[i*PKT_W +: PKT_W];
    end
  end

  assign w_next_ptr = (w_owner == c_ptr_w'(NUM_REQ - 1)) ? '0 : w_owner + c_ptr_w'(1);
  assign w_owner_oh = NUM_REQ'(1) << r_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_hold  <= w_sel_cfg;
            r_owner <= w_owner;
            r_ptr   <= w_next_ptr;
            r_state <= ST_W_STOP;
          end
        end
        ST_W_STOP: r_state <= ST_W_MIN;
        ST_W_MIN:  r_state <= ST_W_MAX;
        ST_W_MAX:  r_state <= ST_W_M0;
        ST_W_M0:   r_state <= ST_W_M1;
        ST_W_M1:   r_state <= ST_W_INIT;
        ST_W_INIT: r_state <= ST_W_CTRL;
        ST_W_CTRL: r_state <= ST_DONE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus is decoded purely from registered state so req/cfg never reach it.
  always_comb begin
    addr   = '0;
    wdata  = '0;
    wr_en  = 1'b0;
    gnt    = '0;
    done   = '0;
    busy   = (r_state != ST_IDLE);
    case (r_state)
      ST_W_STOP: begin
        addr  = ADDR_CTRL;
        wdata = pkt_field(r_hold, CTRL_LSB) & ~c_start_mask;
        wr_en = 1'b1;
        gnt   = w_owner_oh;
      end
      ST_W_MIN:  begin addr = ADDR_MIN;  wdata = pkt_field(r_hold, MIN_LSB);  wr_en = 1'b1; end
      ST_W_MAX:  begin addr = ADDR_MAX;  wdata = pkt_field(r_hold, MAX_LSB);  wr_en = 1'b1; end
      ST_W_M0:   begin addr = ADDR_M0;   wdata = pkt_field(r_hold, M0_LSB);   wr_en = 1'b1; end
      ST_W_M1:   begin addr = ADDR_M1;   wdata = pkt_field(r_hold, M1_LSB);   wr_en = 1'b1; end
      ST_W_INIT: begin addr = ADDR_INIT; wdata = pkt_field(r_hold, INIT_LSB); wr_en = 1'b1; end
      ST_W_CTRL: begin addr = ADDR_CTRL; wdata = pkt_field(r_hold, CTRL_LSB); wr_en = 1'b1; end
      ST_DONE:   done = w_owner_oh;
      default:   ;
    endcase
    mod_en = wr_en;
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// tb_timer_cfg_sequencer : directed bench for timer_cfg_sequencer (NUM_REQ=2).
// Revision               : 1.0
// ============================================================================
module tb_timer_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [95:0] cfg;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        busy;
  logic [5:0]  addr;
  logic        wr_en;
  logic        mod_en;
  logic [7:0]  wdata;

  int total = 0;
  int bad   = 0;

  localparam logic [47:0] P0 = {8'h11, 8'h05, 8'h80, 8'h40, 8'hF0, 8'h02};
  localparam logic [47:0] P1 = {8'h21, 8'h0A, 8'h99, 8'h55, 8'hC0, 8'h01};
  localparam logic [47:0] P2 = {8'h00, 8'h33, 8'h44, 8'h22, 8'h77, 8'h11};

  timer_cfg_sequencer #(.NUM_REQ(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .cfg    (cfg),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .addr   (addr),
    .wr_en  (wr_en),
    .mod_en (mod_en),
    .wdata  (wdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input logic exp_busy);
    chk({tag, " addr"},  addr,   '0);
    chk({tag, " wdata"}, wdata,  '0);
    chk({tag, " wr_en"}, wr_en,  '0);
    chk({tag, " mod_en"}, mod_en, '0);
    chk({tag, " gnt"},   gnt,    '0);
    chk({tag, " done"},  done,   '0);
    chk({tag, " busy"},  busy,   exp_busy);
  endtask

  // Caller is in cycle 0 with req already applied; returns in cycle 'last'.
  task automatic expect_seq(input string name, input int who, input logic [47:0] pkt,
                            input int last, input int chg_cyc, input int drop_cyc);
    logic [5:0] ea;
    logic [7:0] ed;
    logic       ew;
    logic [1:0] oh;
    oh = 2'b01 << who;
    for (int c = 1; c <= last; c++) begin
      tick;
      ew = 1'b1;
      case (c)
        1:       begin ea = 6'h00; ed = pkt[47:40] & 8'hFE; end
        2:       begin ea = 6'h05; ed = pkt[7:0];   end
        3:       begin ea = 6'h06; ed = pkt[15:8];  end
        4:       begin ea = 6'h07; ed = pkt[23:16]; end
        5:       begin ea = 6'h08; ed = pkt[31:24]; end
        6:       begin ea = 6'h04; ed = pkt[39:32]; end
        7:       begin ea = 6'h00; ed = pkt[47:40]; end
        default: begin ea = 6'h00; ed = 8'h00; ew = 1'b0; end
      endcase
      chk($sformatf("%s c%0d addr", name, c),   addr,   ea);
      chk($sformatf("%s c%0d wdata", name, c),  wdata,  ed);
      chk($sformatf("%s c%0d wr_en", name, c),  wr_en,  ew);
      chk($sformatf("%s c%0d mod_en", name, c), mod_en, ew);
      chk($sformatf("%s c%0d gnt", name, c),    gnt,    (c == 1) ? oh : 2'b00);
      chk($sformatf("%s c%0d done", name, c),   done,   (c == 8) ? oh : 2'b00);
      chk($sformatf("%s c%0d busy", name, c),   busy,   1'b1);
      if (c == chg_cyc) cfg[47:0] = '1;
      if (c == drop_cyc) req[who] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    cfg = '0;
    tick;
    tick;
    chk_quiet("reset", 1'b0);
    rst = 1'b0;
    tick;
    chk_quiet("idle", 1'b0);

    // Single request
    cfg[47:0] = P0;
    req = 2'b01;
    expect_seq("single", 0, P0, 8, -1, -1);
    req = 2'b00;
    tick;
    chk_quiet("single c9", 1'b0);
    tick;
    chk_quiet("single c10", 1'b0);

    // Contention from a fresh pointer
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cfg[95:48] = P1;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      expect_seq($sformatf("contend%0d", k), k % 2, (k % 2) ? P1 : P0, 8, -1, -1);
      if (k == 3) req = 2'b00;
      tick;
      chk_quiet($sformatf("contend%0d c9", k), 1'b0);
    end

    // Packet stability: cfg0 goes all-ones mid-sequence
    req = 2'b01;
    expect_seq("stable", 0, P0, 8, 3, -1);
    req = 2'b00;
    cfg[47:0] = P0;
    tick;
    chk_quiet("stable c9", 1'b0);

    // Request dropped mid-sequence
    req = 2'b10;
    expect_seq("drop", 1, P1, 8, -1, 4);
    tick;
    chk_quiet("drop c9", 1'b0);
    tick;
    chk_quiet("drop c10", 1'b0);

    // Reset mid-sequence
    req = 2'b01;
    expect_seq("rstmid", 0, P0, 4, -1, -1);
    rst = 1'b1;
    req = 2'b00;
    tick;
    chk_quiet("rstmid c5", 1'b0);
    rst = 1'b0;
    tick;
    chk_quiet("rstmid c6", 1'b0);
    req = 2'b10;
    expect_seq("after_rst", 1, P1, 8, -1, -1);
    req = 2'b00;
    tick;
    chk_quiet("after_rst c9", 1'b0);

    // Control byte with the start bit already clear
    cfg[47:0] = P2;
    req = 2'b01;
    expect_seq("nostart", 0, P2, 8, -1, -1);
    req = 2'b00;
    tick;
    chk_quiet("nostart c9", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_cfg_sequencer.md
# timer_cfg_sequencer

Register-bus master that programs one timer instance on behalf of up to NUM_REQ requesters. Each requester presents a complete timer configuration packet; a round-robin arbiter picks one. The sequencer then issues a fixed, glitch-free series of single-cycle register writes: stop, limits, compares, initial count, control/start. It sits between the requesters and the timer's addr/wr_en/mod_en/wdata port, so no requester ever drives the timer bus directly.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- START_BIT, 0: bit position of the start bit inside the control byte.
- ADDR_CTRL, 6'h00: control register address (start, mode, clock select, pwm, inv, prescaler).
- ADDR_INIT, 6'h04: counter/initial-value register.
- ADDR_MIN, 6'h05: count-min register.
- ADDR_MAX, 6'h06: count-max register.
- ADDR_M0, 6'h07: compare-0 register.
- ADDR_M1, 6'h08: compare-1 register.

Ports:
- clk, in, 1: single clock for the whole block.
- rst, in, 1: synchronous, active-high reset.
- req, in, NUM_REQ: per-requester request; must be held until the matching done pulse.
- cfg, in, NUM_REQ*48: per-requester packet {ctrl, init, m1, m0, max, min}, 8 bits each, with min in bits [7:0] of each slice.
- gnt, out, NUM_REQ: one-hot grant, one-cycle pulse.
- done, out, NUM_REQ: one-hot completion, one-cycle pulse.
- busy, out, 1: high whenever the sequencer is not idle.
- addr, out, 6: timer register address.
- wr_en, out, 1: timer write strobe.
- mod_en, out, 1: timer module enable; asserted with every write.
- wdata, out, 8: timer write data.

## Operation
- States: IDLE, W_STOP, W_MIN, W_MAX, W_M0, W_M1, W_INIT, W_CTRL, DONE.
- IDLE:
  - If no req bit is set, remain in IDLE.
  - Otherwise the round-robin arbiter picks the winner owner, starting its search at pointer ptr.
  - The owner's cfg slice is latched into a 48-bit holding register.
  - ptr becomes (owner+1) mod NUM_REQ, and the state moves to W_STOP.
- Write states run one per cycle in this fixed order, with wr_en=mod_en=1:
  - W_STOP: addr=ADDR_CTRL, wdata=ctrl with bit START_BIT cleared.
  - W_MIN: addr=ADDR_MIN, wdata=min.
  - W_MAX: addr=ADDR_MAX, wdata=max.
  - W_M0: addr=ADDR_M0, wdata=m0.
  - W_M1: addr=ADDR_M1, wdata=m1.
  - W_INIT: addr=ADDR_INIT, wdata=init.
  - W_CTRL: addr=ADDR_CTRL, wdata=ctrl unmodified.
- DONE: done[owner]=1, bus idle, then return to IDLE.
- gnt[owner]=1 only in W_STOP.
- busy is 1 in every state except IDLE.
- Outside the write states, addr, wdata, wr_en and mod_en are all 0.
- All outputs are decoded from the state register, the owner register and the holding register only. No combinational path runs from req or cfg to any output.
- Once latched, the packet is immune to later cfg or req changes. A req dropped mid-sequence does not abort the sequence; done is still pulsed.
- A ctrl value with the start bit at 0 is written as-is; the timer is left stopped.
- ptr never changes outside IDLE→W_STOP.

## Timing
- Reset values: state=IDLE, ptr=0, owner=0, holding register=0. All outputs are 0.
- Reset mid-sequence:
  - The bus goes quiet on the next cycle, and no done is issued.
  - The timer keeps whatever partial configuration it already received.
- Latency, with req sampled in IDLE at cycle 0:
  - gnt and the first write (W_STOP) occur in cycle 1.
  - Writes occupy cycles 1–7; W_CTRL is in cycle 7.
  - done occurs in cycle 8.
  - IDLE is in cycle 9, and the earliest next grant is cycle 10.
- Throughput: one packet per 9 cycles while requests are continuously pending.
- Simultaneous requests: only one grant per arbitration. Losers keep waiting with req held; no request is lost.
- Fairness: with all NUM_REQ requests continuously asserted, grants rotate 0,1,…,NUM_REQ-1,0.
- NUM_REQ=1: ptr is effectively constant 0, and the block degenerates to a plain sequencer.

## Structure
- Package timer_seq_pkg holds:
  - the state enum;
  - the packet field offsets (MIN_LSB=0, MAX_LSB=8, M0_LSB=16, M1_LSB=24, INIT_LSB=32, CTRL_LSB=40);
  - PKT_W=48.
- Register address defaults stay as module parameters, because the timer map may vary per instance.
- Sub-module timer_rr_arb is parameterized by NUM_REQ. It takes req and ptr and returns the one-hot winner plus the binary owner. It is purely combinational; ptr lives in the sequencer.

## Test plan
- Single request: req[0] at cycle 0 with cfg0={ctrl 8'h11, init 8'h05, m1 8'h80, m0 8'h40, max 8'hF0, min 8'h02}.
  - Bus writes (6'h00,8'h10), (6'h05,8'h02), (6'h06,8'hF0), (6'h07,8'h40), (6'h08,8'h80), (6'h04,8'h05), (6'h00,8'h11) in cycles 1–7.
  - gnt[0] in cycle 1, done[0] in cycle 8, busy high in cycles 1–8.
- Contention: req=2'b11 held continuously → grant order 0,1,0,1 with grants at cycles 1, 10, 19, 28. Each write series carries the granted requester's packet.
- Packet stability: cfg0 changes to all-ones in cycle 3 → remaining writes still carry the originally latched values.
- Request drop: req[1] deasserted in cycle 4 → sequence completes and done[1] is still pulsed in cycle 8.
- Reset mid-sequence: rst in cycle 4 → from cycle 5, wr_en=0 and busy=0, with no done. A new req[1] then grants requester 1 first, since ptr=0 and req[0]=0.
- Start-bit clear: ctrl=8'h00 → both ADDR_CTRL writes carry 8'h00 and done still fires.
